// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, function groups and arbiter state encoding
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 6;

    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_LOGIC = 2'b01;
    localparam logic [1:0] ALU_SHIFT = 2'b10;
    localparam logic [1:0] ALU_CMP   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// rtl/alu_share_arb_rr_arb2.sv - combinational 2-way round-robin one-hot grant
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention the prio side wins.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] & (~valid[1] | ~prio);
        grant[1] = valid[1] & (~valid[0] |  prio);
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - time-shares one combinational ALU between two requesters
module alu_share_arb
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    input  logic [1:0]             req_signed,
    input  logic [1:0][FUNC_W-1:0] req_func,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic                   alu_signed,
    output logic [FUNC_W-1:0]      alu_func,
    input  logic [DATA_W-1:0]      alu_out
);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              signed_q, signed_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        grant;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .prio  (prio_q),
        .grant (grant)
    );

    assign req_ready  = (state_q == IDLE) ? grant : 2'b00;
    assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data   = rsp_data_q;

    // Operand registers feed the ALU directly so its inputs only move on accept.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_signed = signed_q;
    assign alu_func   = func_q;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        signed_d   = signed_q;
        func_d     = func_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d  = grant[1];
                    a_d      = req_a[grant[1]];
                    b_d      = req_b[grant[1]];
                    signed_d = req_signed[grant[1]];
                    func_d   = req_func[grant[1]];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            func_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            signed_q   <= signed_d;
            func_q     <= func_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb
module tb_alu_share_arb;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       req_signed;
    logic [1:0][5:0]  req_func;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic             alu_signed;
    logic [5:0]       alu_func;
    logic [31:0]      alu_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .req_func   (req_func),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_signed (alu_signed),
        .alu_func   (alu_func),
        .alu_out    (alu_out)
    );

    // External ALU stand-in: add/sub, compare (set-less-than), AND otherwise.
    always_comb begin
        alu_out = alu_a & alu_b;
        case (alu_func[5:4])
            2'b00: alu_out = alu_func[0] ? (alu_a - alu_b) : (alu_a + alu_b);
            2'b11: alu_out = alu_signed ? {31'd0, ($signed(alu_a) < $signed(alu_b))}
                                        : {31'd0, (alu_a < alu_b)};
            default: alu_out = alu_a & alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_signed"}, {31'd0, alu_signed}, 32'd0);
        check({tag, "_alu_func"}, {26'd0, alu_func}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_signed = 2'b00;
        req_func   = '0;
        rsp_ready  = 2'b11;
        #2;
        check_reset_outputs("reset");
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request: 5 + 3 on requester 0
        req_valid = 2'b01; req_a[0] = 32'd5; req_b[0] = 32'd3; req_func[0] = 6'b000000;
        #1 check("single_ready", {30'd0, req_ready}, 32'd1);
        tick(); req_valid = 2'b00;
        check("single_exec_a", alu_a, 32'd5);
        check("single_exec_b", alu_b, 32'd3);
        check("single_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        tick();
        check("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("single_rsp_data", rsp_data, 32'd8);
        tick();
        check("single_done", {30'd0, rsp_valid}, 32'd0);

        // Contention from reset
        rst_n = 1'b0; #1; rst_n = 1'b1; tick();
        req_valid = 2'b11;
        req_a[0] = 32'd10; req_b[0] = 32'd4; req_func[0] = 6'b000001;
        req_a[1] = 32'd7;  req_b[1] = 32'd7; req_func[1] = 6'b000000;
        #1 check("cont_ready0", {30'd0, req_ready}, 32'd1);
        tick(); req_valid = 2'b10;
        check("cont_exec_ready", {30'd0, req_ready}, 32'd0);
        tick();
        check("cont_rsp0_valid", {30'd0, rsp_valid}, 32'd1);
        check("cont_rsp0_data", rsp_data, 32'd6);
        tick();
        check("cont_ready1", {30'd0, req_ready}, 32'd2);
        tick();
        rsp_ready = 2'b01;
        req_valid = 2'b01; req_a[0] = 32'd100; req_b[0] = 32'd1; req_func[0] = 6'b000000;
        #1 check("cont_exec1_ready", {30'd0, req_ready}, 32'd0);
        tick();
        check("cont_rsp1_valid", {30'd0, rsp_valid}, 32'd2);
        check("cont_rsp1_data", rsp_data, 32'd14);

        // Back-pressure on requester 1 for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            check("bp_rsp_data", rsp_data, 32'd14);
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 2'b11;
        req_valid = 2'b11; req_a[1] = 32'd1; req_b[1] = 32'd1;
        tick();
        check("bp_release_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("again_ready0", {30'd0, req_ready}, 32'd1);
        tick(); req_valid = 2'b00;
        tick();
        check("again_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("again_rsp_data", rsp_data, 32'd101);
        tick();

        // Signed compare passthrough on requester 1
        req_valid = 2'b10; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
        req_signed = 2'b10; req_func[1] = 6'b110010;
        #1 check("cmp_ready", {30'd0, req_ready}, 32'd2);
        tick(); req_valid = 2'b00;
        check("cmp_alu_signed", {31'd0, alu_signed}, 32'd1);
        check("cmp_alu_func", {26'd0, alu_func}, 32'h32);
        check("cmp_alu_a", alu_a, 32'hFFFF_FFFF);
        tick();
        check("cmp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        check("cmp_rsp_data", rsp_data, 32'd1);
        tick();

        // Reset during EXEC
        req_signed = 2'b00;
        req_valid = 2'b01; req_a[0] = 32'd2; req_b[0] = 32'd2; req_func[0] = 6'b000000;
        tick(); req_valid = 2'b00;
        check("rst_exec_a", alu_a, 32'd2);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11; req_a[0] = 32'd9; req_b[0] = 32'd3; req_func[0] = 6'b000001;
        #1 check("rst_new_ready", {30'd0, req_ready}, 32'd1);
        tick(); req_valid = 2'b00;
        tick();
        check("rst_new_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("rst_new_rsp_data", rsp_data, 32'd6);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
